vga_frame_reader: RTL

VGA_FRAME_READER -- requirements
Module: vga_frame_reader

---
 rtl/vga_frame_reader.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_frame_reader.sv
// ---------------------------------------------------------------------------
// vga_frame_reader
//
// Streams one frame of RGB444 pixels from a fixed-latency framebuffer into a
// small show-ahead FIFO that the display timing stage pops during visible
// pixels. Reads are issued only while the FIFO plus the reads still in flight
// leave room, so the FIFO can never overflow.
//
// Ports
//   clk_50       in   single clock, all state on its rising edge
//   RST          in   synchronous active-high reset
//   FRAME_START  in   one-cycle pulse, restarts the fetch at address 0
//   MEM_RD       out  framebuffer read strobe (one pixel per cycle)
//   MEM_ADDR     out  19-bit linear pixel address, valid with MEM_RD
//   MEM_DATA     in   12-bit read data, valid MEM_LAT cycles after MEM_RD
//   PIX_REQ      in   pop request from the timing stage
//   PIX_RGB      out  FIFO head pixel {R,G,B}, 0 when PIX_VALID=0
//   PIX_VALID    out  FIFO non-empty
//   UNDERFLOW    out  sticky, PIX_REQ seen with an empty FIFO
//   UNDERFLOW_CNT out 16-bit saturating count of underflowing requests
//                     (present only when UNDERFLOW_CNT_EN is defined)
//
// Optional feature macro: UNDERFLOW_CNT_EN
// ---------------------------------------------------------------------------
module vga_frame_reader #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int MEM_LAT    = 2
) (
    input  logic        clk_50,
    input  logic        RST,
    input  logic        FRAME_START,
    output logic        MEM_RD,
    output logic [18:0] MEM_ADDR,
    input  logic [11:0] MEM_DATA,
    input  logic        PIX_REQ,
    output logic [11:0] PIX_RGB,
    output logic        PIX_VALID,
    output logic        UNDERFLOW
`ifdef UNDERFLOW_CNT_EN
    ,
    output logic [15:0] UNDERFLOW_CNT
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    // Room for fifo_count plus every in-flight slot without wrapping.
    localparam int TW = CW + 1;
    localparam logic [18:0] LAST_ADDR = 19'(H_ACTIVE * V_ACTIVE - 1);

    // Number of reads still travelling through the memory pipeline.
    function automatic logic [TW-1:0] popcnt(input logic [MEM_LAT-1:0] v);
        logic [TW-1:0] n;
        n = {TW{1'b0}};
        for (int i = 0; i < MEM_LAT; i++) begin
            if (v[i]) begin
                n = n + TW'(1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic               mem_rd_q,    mem_rd_d;
    logic [18:0]        addr_q,      addr_d;
    logic               exhausted_q, exhausted_d;
    logic [MEM_LAT-1:0] sr_q,        sr_d;
    logic [AW-1:0]      wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]      count_q,     count_d;
    logic               underflow_q, underflow_d;
    logic [11:0]        fifo_q [FIFO_DEPTH];

    logic               empty_s;
    logic               full_s;
    logic               push_s;
    logic               pop_s;
    logic [TW-1:0]      total_d_s;

`ifdef UNDERFLOW_CNT_EN
    logic [15:0]        ucnt_q, ucnt_d;
`endif

    // FIFO status and the push/pop decisions for this cycle.
    always_comb begin
        empty_s = (count_q == {CW{1'b0}});
        full_s  = (count_q == CW'(FIFO_DEPTH));
        // FRAME_START wins over any returning data or pop request.
        pop_s   = PIX_REQ & ~empty_s & ~FRAME_START;
        push_s  = sr_q[MEM_LAT-1] & ~FRAME_START & (~full_s | pop_s);
    end

    // Next-state logic for the fetch side and the FIFO bookkeeping.
    always_comb begin
        addr_d      = addr_q;
        exhausted_d = exhausted_q;
        sr_d        = sr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (FRAME_START) begin
            addr_d      = 19'd0;
            exhausted_d = 1'b0;
            sr_d        = {MEM_LAT{1'b0}};
            wr_ptr_d    = {AW{1'b0}};
            rd_ptr_d    = {AW{1'b0}};
            count_d     = {CW{1'b0}};
        end else begin
            // Slot 0 is the read issued this cycle; the top slot returns now.
            sr_d    = sr_q << 1;
            sr_d[0] = mem_rd_q;
            if (mem_rd_q) begin
                if (addr_q == LAST_ADDR) begin
                    exhausted_d = 1'b1;
                end else begin
                    addr_d = addr_q + 19'd1;
                end
            end else begin
                addr_d = addr_q;
            end
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
        // MEM_RD is registered, so it is decided from the state the next
        // cycle will see: stored pixels plus every read still in flight.
        total_d_s = TW'(count_d) + popcnt(sr_d);
        mem_rd_d  = ~exhausted_d & (total_d_s < TW'(FIFO_DEPTH));
    end

    // Sticky underflow flag: a request that found the FIFO empty.
    always_comb begin
        if (PIX_REQ && empty_s) begin
            underflow_d = 1'b1;
        end else begin
            underflow_d = underflow_q;
        end
    end

`ifdef UNDERFLOW_CNT_EN
    // Saturating count of underflowing request cycles.
    always_comb begin
        if (PIX_REQ && empty_s && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end else begin
            ucnt_d = ucnt_q;
        end
    end

    // Underflow counter register.
    always_ff @(posedge clk_50) begin
        if (RST) begin
            ucnt_q <= 16'd0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign UNDERFLOW_CNT = ucnt_q;
`endif

    // Control state registers.
    always_ff @(posedge clk_50) begin
        if (RST) begin
            mem_rd_q    <= 1'b0;
            addr_q      <= 19'd0;
            exhausted_q <= 1'b0;
            sr_q        <= {MEM_LAT{1'b0}};
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            underflow_q <= 1'b0;
        end else begin
            mem_rd_q    <= mem_rd_d;
            addr_q      <= addr_d;
            exhausted_q <= exhausted_d;
            sr_q        <= sr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Pixel storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_50) begin
        if (!RST && push_s) begin
            fifo_q[wr_ptr_q] <= MEM_DATA;
        end
    end

    // Show-ahead head pixel, forced to zero when nothing is stored.
    always_comb begin
        if (!empty_s) begin
            PIX_RGB = fifo_q[rd_ptr_q];
        end else begin
            PIX_RGB = 12'h000;
        end
    end

    assign PIX_VALID = ~empty_s;
    assign MEM_RD    = mem_rd_q;
    assign MEM_ADDR  = addr_q;
    assign UNDERFLOW = underflow_q;

endmodule
